// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between NUM_REQ requesters.
// Requesters are served in round-robin order, one byte per valid/ready handshake.
// Each accepted byte is launched with a single-cycle data_valid strobe.
// The arbiter then follows uart_tx busy and pulses frame_done at the end of every frame.
// Optional macro UART_ARB_TIMEOUT_EN adds a watchdog on the busy rise.
// The watchdog sets the sticky flag timeout_err when it expires.
// Without the macro, timeout_err is tied low and no counter is built.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_typ,
    output logic [DATA_WIDTH-1:0]         p_data,
    output logic                          data_valid,
    output logic                          par_en,
    output logic                          par_typ,
    input  logic                          busy,
    output logic [GW-1:0]                 grant_id,
    output logic                          frame_done,
    output logic                          timeout_err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] winner;
    logic [GW-1:0] next_ptr;
    logic          any_req;
    logic          grant;

    // Reject parameter values that would produce a meaningless arbiter
    if (NUM_REQ < 1 || NUM_REQ > 8 || BUSY_TIMEOUT < 1 || DATA_WIDTH < 1) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    // Round-robin pick: scanning offsets from high to low leaves the closest valid requester at or after rr_ptr
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                any_req = 1'b1;
                winner  = GW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Handshake is only offered while idle and the serializer is free; at most one ready bit
    always_comb begin
        grant     = (state == IDLE) && !busy && any_req;
        req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
        next_ptr  = (int'(winner) == NUM_REQ - 1) ? '0 : GW'(int'(winner) + 1);
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    logic [CW-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Frame sequencer: latches the accepted word, strobes the launch and tracks busy through the frame
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            p_data     <= '0;
            par_en     <= 1'b0;
            par_typ    <= 1'b0;
            grant_id   <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        p_data     <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        par_en     <= cfg_par_en;
                        par_typ    <= cfg_par_typ;
                        grant_id   <= winner;
                        rr_ptr     <= next_ptr;
                        data_valid <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        state <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (to_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        // Serializer never picked the word up: abandon it without frame_done
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed sequence plus randomized frames, checked
// against a round-robin reference model kept in the bench.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            res_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cfg_par_en, cfg_par_typ;
    logic [DW-1:0]   p_data;
    logic            data_valid, par_en, par_typ, busy;
    logic [1:0]      grant_id;
    logic            frame_done, timeout_err;

    int tests = 0;
    int fails = 0;

    // reference model state
    int          ptr_m;
    logic [7:0]  exp_data;
    logic        exp_pe, exp_pt;
    int          exp_gid;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BUSY_TIMEOUT(16)) dut (
        .clk(clk), .res_n(res_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
        .p_data(p_data), .data_valid(data_valid), .par_en(par_en), .par_typ(par_typ),
        .busy(busy), .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Round robin: first valid requester at or after the pointer, wrapping
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Called at a negedge with DUT idle and busy low: offer request, check handshake and launch
    task automatic accept(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic pe, input logic pt);
        int w;
        req_valid = v; req_data = d; cfg_par_en = pe; cfg_par_typ = pt;
        #1;
        w = rr_pick(v, ptr_m);
        check("req_ready", 32'(req_ready), 32'(1) << w);
        exp_data = d[w*DW +: DW];
        exp_pe   = pe;
        exp_pt   = pt;
        exp_gid  = w;
        ptr_m    = (w + 1) % N;
        @(negedge clk);
        check("launch_dv", 32'(data_valid), 32'd1);
        check("launch_pdata", 32'(p_data), 32'(exp_data));
        check("launch_par_en", 32'(par_en), 32'(exp_pe));
        check("launch_par_typ", 32'(par_typ), 32'(exp_pt));
        check("launch_gid", 32'(grant_id), 32'(exp_gid));
        check("launch_ready0", 32'(req_ready), 32'd0);
        check("launch_fd0", 32'(frame_done), 32'd0);
        req_valid   = '0;
        cfg_par_en  = 1'($urandom);
        cfg_par_typ = 1'($urandom);
    endtask

    // Run busy through a frame of 'hold' cycles, toggling config, then expect frame_done
    task automatic finish(input int hold);
        @(negedge clk);
        check("dv_single", 32'(data_valid), 32'd0);
        busy = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("mid_fd0", 32'(frame_done), 32'd0);
            check("mid_pdata", 32'(p_data), 32'(exp_data));
            check("mid_par_typ", 32'(par_typ), 32'(exp_pt));
            check("mid_par_en", 32'(par_en), 32'(exp_pe));
            check("mid_ready0", 32'(req_ready), 32'd0);
            cfg_par_typ = ~cfg_par_typ;
        end
        busy = 1'b0;
        @(negedge clk);
        check("frame_done", 32'(frame_done), 32'd1);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        res_n = 1'b0; req_valid = '0; req_data = '0;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0; busy = 1'b0;
        ptr_m = 0;
        repeat (2) @(negedge clk);
        check("rst_pdata", 32'(p_data), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_par", 32'({par_en, par_typ}), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_to", 32'(timeout_err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        res_n = 1'b1;
        @(negedge clk);

        // all requesters valid: strict round robin 0,1,2,3,0
        for (int f = 0; f < 5; f++) begin
            accept(4'b1111, 32'h1312_1110, 1'b0, 1'b0);
            check("rr_gid", 32'(grant_id), 32'(f % 4));
            check("rr_pdata", 32'(p_data), 32'h10 + 32'(f % 4));
            finish($urandom_range(1, 4));
        end

        // single request with parity odd
        accept(4'b0001, 32'h0000_00A5, 1'b1, 1'b1);
        finish(3);
        @(negedge clk);
        check("fd_one_pulse", 32'(frame_done), 32'd0);

        // busy high in idle blocks the grant
        busy = 1'b1; req_valid = 4'b0100; req_data = 32'h0077_0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("busy_no_ready", 32'(req_ready), 32'd0);
            check("busy_no_dv", 32'(data_valid), 32'd0);
            @(negedge clk);
        end
        busy = 1'b0;
        accept(4'b0100, 32'h0077_0000, 1'b0, 1'b1);
        check("busy_gid", 32'(grant_id), 32'd2);
        finish(2);

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            accept(4'($urandom_range(1, 15)), 32'($urandom), 1'($urandom), 1'($urandom));
            finish($urandom_range(1, 5));
        end

        // reset in the middle of a frame
        accept(4'b0001, 32'h0000_003C, 1'b1, 1'b1);
        @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        res_n = 1'b0;
        #1;
        check("arst_pdata", 32'(p_data), 32'd0);
        check("arst_par", 32'({par_en, par_typ}), 32'd0);
        check("arst_gid", 32'(grant_id), 32'd0);
        check("arst_dv_fd", 32'({data_valid, frame_done}), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd0);
        busy = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        accept(4'b0010, 32'h0000_5500, 1'b0, 1'b0);
        check("post_rst_gid", 32'(grant_id), 32'd1);
        finish(2);

`ifdef UART_ARB_TIMEOUT_EN
        // busy never rises: watchdog returns to idle with sticky error
        accept(4'b1000, 32'h9900_0000, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("to_pending", 32'(timeout_err), 32'd0);
            check("to_no_fd", 32'(frame_done), 32'd0);
        end
        @(negedge clk);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_no_fd_end", 32'(frame_done), 32'd0);
        accept(4'($urandom_range(1, 15)), 32'($urandom), 1'b1, 1'b1);
        finish(2);
        check("to_sticky", 32'(timeout_err), 32'd1);
`else
        check("to_tied0", 32'(timeout_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
